// File: rtl/fp16_harness_pkg.sv
`default_nettype none
// ============================================================================
// fp16_harness_pkg : shared types and FP16 boundary constants for the sweep
// Revision: 1.0
// ============================================================================
package fp16_harness_pkg;

  localparam int MAX_LANES = 8;

  localparam logic [15:0] MIN_POS               = 16'h0400;
  localparam logic [15:0] MAX_POS               = 16'h7BFF;
  localparam logic [15:0] MIN_NEG               = 16'h8400;
  localparam logic [15:0] MAX_NEG_NON_SUBNORMAL = 16'hFBFF;
  localparam logic [15:0] FP16_ONE              = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mask is sized for the widest legal lane count; unused lanes stay zero.
  typedef struct packed {
    logic [15:0]          a;
    logic [15:0]          x_base;
    logic [MAX_LANES-1:0] mask;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp16_sweep_harness_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy counter and full/empty flags
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr     = push && !full;
  assign w_rd     = pop && !empty;
  assign full     = (r_count == c_FULL);
  assign empty    = (r_count == '0);
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fp16_sweep_harness.sv
`default_nettype none
// ============================================================================
// fp16_sweep_harness : sweeps (alpha, x) raw FP16 codes into a DUT and
//                      re-aligns the DUT results with their issue tags
// Revision: 1.0
// ============================================================================
module fp16_sweep_harness
  import fp16_harness_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int TAG_DEPTH = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [15:0]         x_lo,
  input  logic [15:0]         x_hi,
  input  logic [15:0]         a_lo,
  input  logic [15:0]         a_hi,
  output logic                dut_ivalid,
  input  logic                dut_iready,
  output logic [16*LANES-1:0] dut_x,
  output logic [15:0]         dut_a,
  input  logic                dut_ovalid,
  output logic                dut_oready,
  input  logic [16*LANES-1:0] dut_y,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [15:0]         res_a,
  output logic [15:0]         res_x,
  output logic [16*LANES-1:0] res_y,
  output logic [LANES-1:0]    res_mask,
  output logic                busy,
  output logic                done,
  output logic                err_range,
  output logic                err_proto,
  output logic [31:0]         beats
);

  state_t          r_state;
  logic [15:0]     r_x_lo;
  logic [15:0]     r_x_hi;
  logic [15:0]     r_a_hi;
  logic [15:0]     r_x_base;
  logic [15:0]     r_a;
  logic [31:0]     r_beats;
  logic            r_busy;
  logic            r_done;
  logic            r_err_range;
  logic            r_err_proto;

  tag_t            w_tag_in;
  tag_t            w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_issue;
  logic            w_pop;
  logic            w_wrap;
  logic [16:0]     w_next_x;
  logic [MAX_LANES-1:0] w_mask;
  logic            w_unused_mask;

  // 17-bit arithmetic keeps x_hi = FFFF from wrapping back into range.
  assign w_next_x = {1'b0, r_x_base} + 17'(LANES);
  assign w_wrap   = w_next_x > {1'b0, r_x_hi};

  generate
    for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
      if (gi < LANES) begin : g_live
        assign w_mask[gi]          = ({1'b0, r_x_base} + 17'(gi)) <= {1'b0, r_x_hi};
        assign dut_x[16*gi +: 16]  = r_x_base + 16'(gi);
      end else begin : g_pad
        assign w_mask[gi] = 1'b0;
      end
    end
  endgenerate

  assign dut_a      = r_a;
  assign dut_ivalid = resetn && (r_state == RUN) && !w_full;
  assign dut_oready = resetn && res_ready && !w_empty;
  assign res_valid  = resetn && dut_ovalid && !w_empty;
  assign w_issue    = dut_ivalid && dut_iready;
  assign w_pop      = dut_ovalid && dut_oready;

  assign w_tag_in.a      = r_a;
  assign w_tag_in.x_base = r_x_base;
  assign w_tag_in.mask   = w_mask;

  assign res_a         = w_head.a;
  assign res_x         = w_head.x_base;
  assign res_mask      = w_head.mask[LANES-1:0];
  assign res_y         = dut_y;
  assign w_unused_mask = ^w_head.mask;

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_range = r_err_range;
  assign err_proto = r_err_proto;
  assign beats     = r_beats;

  sync_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (w_issue),
    .push_data (w_tag_in),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_x_lo      <= '0;
      r_x_hi      <= '0;
      r_a_hi      <= '0;
      r_x_base    <= '0;
      r_a         <= '0;
      r_beats     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A result with no tag outstanding is dropped and flagged.
      if (dut_ovalid && w_empty) r_err_proto <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x_lo  <= x_lo;
            r_x_hi  <= x_hi;
            r_a_hi  <= a_hi;
            r_beats <= '0;
            if ((x_lo > x_hi) || (a_lo > a_hi)) begin
              r_err_range <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_err_range <= 1'b0;
              r_x_base    <= x_lo;
              r_a         <= a_lo;
              r_busy      <= 1'b1;
              r_state     <= RUN;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_beats <= r_beats + 32'd1;
            if (w_wrap) begin
              r_x_base <= r_x_lo;
              r_a      <= r_a + 16'd1;
              if (r_a == r_a_hi) r_state <= DRAIN;
            end else begin
              r_x_base <= w_next_x[15:0];
            end
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_sweep_harness.sv
`default_nettype none
// ============================================================================
// tb_fp16_sweep_harness : directed bench with a latency-model DUT and a
//                         scoreboard of expected result beats
// Revision: 1.0
// ============================================================================
module tb_fp16_sweep_harness;
  import fp16_harness_pkg::*;

  localparam int LANES     = 4;
  localparam int TAG_DEPTH = 4;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                start = 1'b0;
  logic [15:0]         x_lo = '0, x_hi = '0, a_lo = '0, a_hi = '0;
  logic                dut_ivalid;
  logic                dut_iready;
  logic [16*LANES-1:0] dut_x;
  logic [15:0]         dut_a;
  logic                dut_ovalid;
  logic                dut_oready;
  logic [16*LANES-1:0] dut_y;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [15:0]         res_a, res_x;
  logic [16*LANES-1:0] res_y;
  logic [LANES-1:0]    res_mask;
  logic                busy, done, err_range, err_proto;
  logic [31:0]         beats;

  fp16_sweep_harness #(.LANES(LANES), .TAG_DEPTH(TAG_DEPTH)) u_dut (
    .clock(clock), .resetn(resetn), .start(start),
    .x_lo(x_lo), .x_hi(x_hi), .a_lo(a_lo), .a_hi(a_hi),
    .dut_ivalid(dut_ivalid), .dut_iready(dut_iready), .dut_x(dut_x), .dut_a(dut_a),
    .dut_ovalid(dut_ovalid), .dut_oready(dut_oready), .dut_y(dut_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_x(res_x),
    .res_y(res_y), .res_mask(res_mask), .busy(busy), .done(done),
    .err_range(err_range), .err_proto(err_proto), .beats(beats)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]         a;
    logic [15:0]         x;
    logic [LANES-1:0]    mask;
    logic [16*LANES-1:0] y;
  } exp_t;

  typedef struct {
    logic [16*LANES-1:0] x;
    logic [15:0]         a;
    int                  t;
  } pipe_t;

  exp_t  sbq[$];
  pipe_t pipe[$];
  int    total = 0;
  int    bad = 0;
  int    lat = 3;
  int    n_issue = 0;
  int    cyc = 0;
  bit    bp = 1'b0;
  bit    inject = 1'b0;
  bit    model_flush = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Reference sweep: x runs lo..hi in LANES steps for every alpha lo..hi.
  task automatic expect_sweep(input int xl, input int xh, input int al, input int ah, output int nb);
    exp_t e;
    int   xb;
    bit   fin;
    nb = 0;
    for (int a = al; a <= ah; a++) begin
      xb  = xl;
      fin = 1'b0;
      while (!fin) begin
        e.a = 16'(a); e.x = 16'(xb); e.mask = '0; e.y = '0;
        for (int i = 0; i < LANES; i++) begin
          if (xb + i <= xh) e.mask[i] = 1'b1;
          e.y[16*i +: 16] = 16'(xb + i) + 16'(a);
        end
        sbq.push_back(e);
        nb++;
        if (xb + LANES > xh) fin = 1'b1;
        else xb += LANES;
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] xl, input logic [15:0] xh,
                             input logic [15:0] al, input logic [15:0] ah);
    x_lo = xl; x_hi = xh; a_lo = al; a_hi = ah;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  // Latency model of the DUT: y lane = x lane + alpha, released after lat cycles.
  initial begin
    logic                iss, pp;
    logic [16*LANES-1:0] cx;
    logic [15:0]         ca;
    exp_t                e;
    dut_ovalid = 1'b0;
    dut_y      = '0;
    dut_iready = 1'b1;
    forever begin
      @(negedge clock);
      iss = dut_ivalid && dut_iready;
      pp  = dut_ovalid && dut_oready;
      cx  = dut_x;
      ca  = dut_a;
      if (res_valid && res_ready) begin
        check("sb_has_entry", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("res_a", 64'(res_a), 64'(e.a));
          check("res_x", 64'(res_x), 64'(e.x));
          check("res_mask", 64'(res_mask), 64'(e.mask));
          check("res_y", 64'(res_y), 64'(e.y));
        end
      end
      @(posedge clock);
      #1;
      cyc++;
      if (model_flush) begin
        pipe.delete();
      end else begin
        if (pp && pipe.size() > 0) void'(pipe.pop_front());
        if (iss) begin
          pipe.push_back('{x: cx, a: ca, t: cyc + lat});
          n_issue++;
        end
      end
      dut_ovalid = inject || (pipe.size() > 0 && pipe[0].t <= cyc);
      dut_y      = '0;
      if (inject) begin
        dut_y = {LANES{16'hBEEF}};
      end else if (pipe.size() > 0) begin
        for (int i = 0; i < LANES; i++)
          dut_y[16*i +: 16] = pipe[0].x[16*i +: 16] + pipe[0].a;
      end
      dut_iready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int nb;
    int base;
    bit seen;

    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    check("rst_ivalid", 64'(dut_ivalid), 64'd0);
    check("rst_oready", 64'(dut_oready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_beats", 64'(beats), 64'd0);
    check("rst_err_range", 64'(err_range), 64'd0);
    check("rst_err_proto", 64'(err_proto), 64'd0);
    resetn = 1'b1;
    tick();

    // Single partial beat over negative normals, long latency, stray start in RUN
    lat = 11;
    expect_sweep(int'(MIN_NEG), 32'h8402, int'(FP16_ONE), int'(FP16_ONE), nb);
    pulse_start(MIN_NEG, 16'h8402, FP16_ONE, FP16_ONE);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_ivalid", 64'(dut_ivalid), 64'd1);
    x_lo = 16'h0000; x_hi = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("s1_done_seen", 80);
    check("s1_beats", 64'(beats), 64'(nb));
    check("s1_err_range", 64'(err_range), 64'd0);
    check("s1_sb_empty", 64'(sbq.size()), 64'd0);
    tick();
    check("s1_done_one_cycle", 64'(done), 64'd0);
    check("s1_busy_after", 64'(busy), 64'd0);

    // Two alphas, partial second beat, random input backpressure, inputs changed after start
    lat = 3;
    bp  = 1'b1;
    expect_sweep(int'(MIN_POS), 32'h0405, 32'h3BFF, int'(FP16_ONE), nb);
    pulse_start(MIN_POS, 16'h0405, 16'h3BFF, FP16_ONE);
    x_lo = MAX_POS; x_hi = 16'h0000; a_lo = 16'h0000; a_hi = 16'hFFFF;
    wait_done("s2_done_seen", 200);
    check("s2_beats", 64'(beats), 64'd4);
    check("s2_sb_empty", 64'(sbq.size()), 64'd0);
    bp = 1'b0;
    tick();

    // Top of the code space: x_base must return to FFFE, no 16-bit wrap
    lat = 2;
    expect_sweep(32'hFFFE, 32'hFFFF, 0, 2, nb);
    pulse_start(16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002);
    wait_done("s3_done_seen", 100);
    check("s3_beats", 64'(beats), 64'd3);
    check("s3_sb_empty", 64'(sbq.size()), 64'd0);
    tick();

    // Result backpressure fills the tag FIFO, then drains in order
    lat = 9;
    res_ready = 1'b0;
    expect_sweep(0, 31, int'(FP16_ONE), int'(FP16_ONE), nb);
    base = n_issue;
    pulse_start(16'h0000, 16'd31, FP16_ONE, FP16_ONE);
    repeat (30) tick();
    check("s4_issues_capped", 64'(n_issue - base), 64'(TAG_DEPTH));
    check("s4_ivalid_stalled", 64'(dut_ivalid), 64'd0);
    check("s4_busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    wait_done("s4_done_seen", 300);
    check("s4_beats", 64'(beats), 64'd8);
    check("s4_sb_empty", 64'(sbq.size()), 64'd0);
    tick();

    // Illegal ranges go straight to DONE
    base = n_issue;
    pulse_start(MAX_POS, MIN_POS, FP16_ONE, FP16_ONE);
    check("s5_done", 64'(done), 64'd1);
    check("s5_err_range", 64'(err_range), 64'd1);
    check("s5_beats", 64'(beats), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_ivalid", 64'(dut_ivalid), 64'd0);
    tick();
    check("s5_done_drop", 64'(done), 64'd0);
    pulse_start(16'h0000, 16'h0001, 16'h3C01, FP16_ONE);
    check("s5b_err_range", 64'(err_range), 64'd1);
    check("s5b_done", 64'(done), 64'd1);
    tick();
    check("s5_no_issue", 64'(n_issue - base), 64'd0);

    // Result with no tag outstanding
    inject = 1'b1;
    tick();
    check("s6_oready_empty", 64'(dut_oready), 64'd0);
    check("s6_res_valid_empty", 64'(res_valid), 64'd0);
    tick();
    inject = 1'b0;
    check("s6_err_proto", 64'(err_proto), 64'd1);
    repeat (2) tick();
    check("s6_err_proto_sticky", 64'(err_proto), 64'd1);
    resetn = 1'b0;
    tick();
    check("s6_err_proto_rst", 64'(err_proto), 64'd0);
    resetn = 1'b1;
    tick();

    // Reset in the middle of a sweep abandons in-flight tags
    lat = 9;
    pulse_start(16'h0000, 16'h00FF, 16'h0000, 16'h0000);
    repeat (4) tick();
    check("s7_busy", 64'(busy), 64'd1);
    check("s7_beats", 64'(beats), 64'd4);
    resetn = 1'b0;
    tick();
    check("s7_ivalid", 64'(dut_ivalid), 64'd0);
    check("s7_oready", 64'(dut_oready), 64'd0);
    check("s7_res_valid", 64'(res_valid), 64'd0);
    check("s7_busy_rst", 64'(busy), 64'd0);
    check("s7_done", 64'(done), 64'd0);
    check("s7_beats_rst", 64'(beats), 64'd0);
    check("s7_err_proto", 64'(err_proto), 64'd0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (err_proto) begin seen = 1'b1; break; end
    end
    check("s7_late_result_proto", 64'(seen), 64'd1);
    check("s7_late_res_valid", 64'(res_valid), 64'd0);
    model_flush = 1'b1;
    tick();
    model_flush = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
